// File: rtl/score_keeper.sv
// ============================================================================
// score_keeper : saturating game score engine with hit combo and high score
// Rev 1.0
// ============================================================================
`default_nettype none

module score_keeper #(
    parameter int MAX_SCORE     = 999,
    parameter int PENALTY_VALUE = 5,
    parameter int COMBO_WINDOW  = 60,
    parameter int COMBO_MAX     = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_in,
    input  logic       hit_in,
    input  logic [3:0] hit_value,
    input  logic       penalty_in,
    input  logic       game_over_in,
    output logic [9:0] score_out,
    output logic [9:0] high_score,
    output logic [1:0] combo_level,
    output logic       playing,
    output logic       score_changed
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    localparam int              TW           = $clog2(COMBO_WINDOW + 1);
    localparam logic [TW-1:0]   C_TIMER_LOAD = TW'(COMBO_WINDOW - 1);
    localparam logic [1:0]      C_COMBO_MAX  = 2'(COMBO_MAX);
    localparam logic [11:0]     C_PENALTY    = 12'(PENALTY_VALUE);
    localparam logic [11:0]     C_MAX_SCORE  = 12'(MAX_SCORE);

    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;
    logic          r_start_d;
    logic          r_hit_d;
    logic          r_pen_d;

    logic          w_start_ev;
    logic          w_hit_ev;
    logic          w_pen_ev;
    logic [1:0]    w_state_nxt;
    logic [9:0]    w_score_nxt;
    logic [9:0]    w_high_nxt;
    logic [1:0]    w_combo_nxt;
    logic [1:0]    w_combo_hit;
    logic [TW-1:0] w_timer_nxt;
    logic [6:0]    w_points;
    logic [11:0]   w_sum;

    assign w_start_ev = start_in   & ~r_start_d;
    assign w_hit_ev   = hit_in     & ~r_hit_d;
    assign w_pen_ev   = penalty_in & ~r_pen_d;

    always_comb begin
        w_state_nxt = r_state;
        w_score_nxt = score_out;
        w_high_nxt  = high_score;
        w_combo_nxt = combo_level;
        w_combo_hit = combo_level;
        w_timer_nxt = (r_timer != '0) ? r_timer - 1'b1 : '0;
        w_points    = '0;
        w_sum       = '0;

        case (r_state)
            S_IDLE, S_OVER: begin
                if (w_start_ev) begin
                    w_state_nxt = S_PLAY;
                    w_score_nxt = '0;
                    w_combo_nxt = '0;
                    w_timer_nxt = '0;
                end
            end
            S_PLAY: begin
                // Game over wins over any same-cycle hit or penalty.
                if (game_over_in) begin
                    w_state_nxt = S_OVER;
                    w_high_nxt  = (score_out > high_score) ? score_out : high_score;
                end else begin
                    if (w_hit_ev) begin
                        if (r_timer != '0)
                            w_combo_hit = (combo_level >= C_COMBO_MAX) ? C_COMBO_MAX
                                                                       : combo_level + 2'd1;
                        else
                            w_combo_hit = '0;
                        w_points    = {3'b000, hit_value} << w_combo_hit;
                        w_combo_nxt = w_combo_hit;
                        w_timer_nxt = C_TIMER_LOAD;
                    end
                    if (w_pen_ev) begin
                        w_combo_nxt = '0;
                        w_timer_nxt = '0;
                    end
                    w_sum = {2'b00, score_out} + {5'b00000, w_points}
                          - (w_pen_ev ? C_PENALTY : 12'd0);
                    if ($signed(w_sum) < 0)
                        w_score_nxt = '0;
                    else if ($signed(w_sum) > $signed(C_MAX_SCORE))
                        w_score_nxt = C_MAX_SCORE[9:0];
                    else
                        w_score_nxt = w_sum[9:0];
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_start_d     <= 1'b0;
            r_hit_d       <= 1'b0;
            r_pen_d       <= 1'b0;
            score_out     <= '0;
            high_score    <= '0;
            combo_level   <= '0;
            playing       <= 1'b0;
            score_changed <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_start_d     <= start_in;
            r_hit_d       <= hit_in;
            r_pen_d       <= penalty_in;
            score_out     <= w_score_nxt;
            high_score    <= w_high_nxt;
            combo_level   <= w_combo_nxt;
            playing       <= (w_state_nxt == S_PLAY);
            score_changed <= (w_score_nxt != score_out);
        end
    end

endmodule

`default_nettype wire

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-side score engine that produces the 10-bit score value sampled by the score-value input PIO, which the NIOS reads over Avalon.
- Converts collision/event strobes from the game logic into a saturating score with a hit-combo multiplier, and tracks a session high score.
- Runs a small game state machine (IDLE/PLAY/OVER) so score only moves during play.

Parameters:
- MAX_SCORE, 999, saturation ceiling for score_out and high_score (must be ≤1023)
- PENALTY_VALUE, 5, points subtracted per penalty event
- COMBO_WINDOW, 60, cycles after a hit during which the next hit raises the combo level
- COMBO_MAX, 3, maximum combo level; hit points = hit_value << combo_level

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start_in  in  1  level from game logic; rising edge starts a game
- hit_in  in  1  level from collision logic; rising edge = one hit event
- hit_value  in  4  base points for the hit, sampled on the hit_in rising-edge cycle
- penalty_in  in  1  level; rising edge = one penalty event
- game_over_in  in  1  level; while high in PLAY, the game ends
- score_out  out  10  current score, wired to the score-value PIO in_port
- high_score  out  10  best score this power-up
- combo_level  out  2  current combo level
- playing  out  1  high in PLAY
- score_changed  out  1  one-cycle pulse when score_out changes value

Behaviour:
- Reset (asynchronous, reset_n low): state=IDLE; score_out=0, high_score=0, combo_level=0, combo timer=0, playing=0, score_changed=0; edge-detect registers cleared to 0. Reset mid-game discards everything, including high_score.
- Edge detect: each of start_in, hit_in, penalty_in is registered; event = in & ~in_d. A held level produces exactly one event.
- States:
  - IDLE -> PLAY on a start event. On entry: score_out=0, combo_level=0, timer=0.
  - PLAY -> OVER when game_over_in=1. This takes priority over hit/penalty events in the same cycle; those events are dropped.
  - OVER: on entry, high_score = max(high_score, score_out) in the same edge. OVER -> PLAY on a start event, clearing score and combo as on IDLE entry. score_out holds in OVER.
- Hit/penalty events outside PLAY are ignored.
- Latency: an event sampled at clock edge k updates score_out, combo_level and score_changed after edge k, so they are visible in the cycle following k.
- Combo:
  - Timer loads COMBO_WINDOW-1 on every hit and decrements to 0 otherwise.
  - On a hit: if timer≠0, combo_level = min(combo_level+1, COMBO_MAX); else combo_level=0.
  - Points = hit_value << new combo_level, computed in 7 bits.
  - A penalty event clears combo_level and the timer to 0.
- Arithmetic:
  - next = score_out + points − (penalty ? PENALTY_VALUE : 0), computed signed 12-bit.
  - Clamp the result to [0, MAX_SCORE].
  - Simultaneous hit and penalty: both apply in one update. The hit's combo level is computed first, then the penalty clears combo state, so combo_level=0 afterwards.
- score_changed = 1 for one cycle iff the registered score differs from its previous value; saturated no-op hits do not pulse.
- playing = (state==PLAY), registered.

Test Plan:
- Reset then start event; hit_value=7, one hit -> score_out=7 one cycle after the sampling edge, combo_level=0, score_changed pulses once. Holding hit_in high 20 cycles adds nothing more.
- Hits of value 3 at cycles 0, 10, 20, 30, 40 (within window) -> combo 0,1,2,3,3; score 3, 9, 21, 45, 69. Next hit 100 cycles later -> combo 0, score 72.
- Score 2, penalty event -> score 0, combo 0, score_changed pulses. A second penalty -> score stays 0, no pulse.
- Score 990, hit_value=15 at combo 0 -> score 999. A further hit -> 999, no score_changed pulse.
- Same-cycle hit (value 4, combo 0) + penalty at score 10 -> score 9, combo_level=0. Same-cycle hit + game_over_in -> score unchanged, state OVER, high_score updated.
- Game 1 ends at 50, game 2 ends at 30 -> high_score=50. Restart from OVER clears score_out to 0. Assert reset_n mid-PLAY -> all outputs 0 immediately (asynchronously).
